neuron_term_loader: RTL and testbench

Serial front end that builds the 33-term signed vector consumed by the neuron adder tree: 32 weighted products plus one bias. Accepts one (input, weight) pair per handshake and multiplies it in fixed point. Stores each product in a term bank and presents the completed vector with a valid/ready handshake. Sits between the weight/activation streamer and the `summer` block.

---
 rtl/neuron_pkg.sv | 24 ++
 rtl/fx_mul_narrow.sv | 46 ++++
 rtl/neuron_term_loader.sv | 103 ++++++++++
 tb/tb_neuron_term_loader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared widths, term types and loader state encoding
//
// Purpose: constants and types common to neuron_term_loader and summer.
// Ports: none (package).
// Configuration macro: NEURON_TERM_SAT_EN (consumed by fx_mul_narrow only).

package neuron_pkg;

  localparam int N_INPUTS  = 32;
  localparam int DATA_W    = 32;
  localparam int FRAC_BITS = 16;
  localparam int SUM_W     = 64;
  localparam int IDX_W     = $clog2(N_INPUTS + 1);

  typedef logic signed [DATA_W-1:0] term_t;
  typedef term_t [N_INPUTS:0]       term_vec_t;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/fx_mul_narrow.sv
// rtl/fx_mul_narrow.sv - combinational Q-format multiply, floor shift and narrow
//
// Purpose: y = floor((a * b) / 2^FRAC_BITS), narrowed to DATA_W bits.
// Ports:
//   i_a  in  DATA_W  signed multiplicand
//   i_b  in  DATA_W  signed multiplier
//   o_y  out DATA_W  narrowed product
// Configuration macro: NEURON_TERM_SAT_EN
//   defined   -> result saturates to the signed DATA_W range
//   undefined -> low DATA_W bits are kept (wraps)

module fx_mul_narrow
  import neuron_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_y
);

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [2*DATA_W-1:0] w_shift;

  assign w_prod  = $signed(i_a) * $signed(i_b);
  // Arithmetic shift of a two's complement value rounds toward -inf (floor).
  assign w_shift = w_prod >>> FRAC_BITS;

`ifdef NEURON_TERM_SAT_EN
  // The value fits in DATA_W bits only if the top DATA_W+1 bits are all copies
  // of the sign; otherwise clamp in the direction of the sign.
  logic [DATA_W:0] w_hi;
  assign w_hi = w_shift[2*DATA_W-1:DATA_W-1];

  always_comb begin
    o_y = w_shift[DATA_W-1:0];
    if (!((&w_hi) || (~|w_hi))) begin
      if (w_hi[DATA_W]) o_y = {1'b1, {(DATA_W-1){1'b0}}};
      else              o_y = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  logic w_unused_hi;
  assign w_unused_hi = ^w_shift[2*DATA_W-1:DATA_W];
  assign o_y         = w_shift[DATA_W-1:0];
`endif

endmodule

// File: rtl/neuron_term_loader.sv
// rtl/neuron_term_loader.sv - serial loader building the 33-term neuron vector
//
// Purpose: accepts one (x, w) pair per handshake, multiplies it through a
// one-entry stage into a term bank, takes the bias as the last element and
// presents the whole vector with a valid/ready handshake.
// Ports:
//   clk        in   1                          rising-edge clock
//   rst_n      in   1                          asynchronous active-low reset
//   flush      in   1                          drop partial vector (ignored when full)
//   in_valid   in   1                          pair / bias present
//   in_ready   out  1                          loader accepts (state decode)
//   in_x       in   DATA_W                     activation, or bias at last index
//   in_w       in   DATA_W                     weight, ignored for bias
//   out_valid  out  1                          full vector available
//   out_ready  in   1                          downstream takes vector
//   out_terms  out  [N_INPUTS:0][DATA_W-1:0]   term vector, top element is bias
// Configuration macro: NEURON_TERM_SAT_EN (see fx_mul_narrow).

module neuron_term_loader
  import neuron_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              in_x,
  input  logic [DATA_W-1:0]              in_w,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_INPUTS:0][DATA_W-1:0]  out_terms
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_stg_vld;
  logic [DATA_W-1:0] r_stg_x;
  logic [DATA_W-1:0] r_stg_w;
  logic [IDX_W-1:0] r_stg_idx;
  term_vec_t        r_terms;

  logic              w_accept;
  logic              w_flush_act;
  logic [DATA_W-1:0] w_prod;
  logic [DATA_W-1:0] w_term;

  fx_mul_narrow u_mul (
    .i_a (r_stg_x),
    .i_b (r_stg_w),
    .o_y (w_prod)
  );

  assign in_ready    = (r_state == ST_LOAD);
  assign out_valid   = (r_state == ST_FULL);
  assign out_terms   = r_terms;
  assign w_accept    = in_valid & in_ready;
  // A presented vector is never retracted, so flush only acts before FULL.
  assign w_flush_act = flush & (r_state != ST_FULL);
  assign w_term      = (r_stg_idx == LAST_IDX) ? r_stg_x : w_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_LOAD;
      r_idx     <= '0;
      r_stg_vld <= 1'b0;
      r_stg_x   <= '0;
      r_stg_w   <= '0;
      r_stg_idx <= '0;
      r_terms   <= '0;
    end else if (w_flush_act) begin
      // The pending stage entry is discarded, not written.
      r_state   <= ST_LOAD;
      r_idx     <= '0;
      r_stg_vld <= 1'b0;
    end else begin
      r_stg_vld <= w_accept;
      if (r_stg_vld) r_terms[r_stg_idx] <= w_term;
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            r_stg_x   <= in_x;
            r_stg_w   <= in_w;
            r_stg_idx <= r_idx;
            r_idx     <= r_idx + 1'b1;
            if (r_idx == LAST_IDX) r_state <= ST_DRAIN;
          end
        end
        // The bias sits in the stage during DRAIN and is written this edge.
        ST_DRAIN: r_state <= ST_FULL;
        ST_FULL: begin
          if (out_ready) begin
            r_state <= ST_LOAD;
            r_idx   <= '0;
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_term_loader.sv
// tb/tb_neuron_term_loader.sv - self-checking bench for neuron_term_loader

module tb_neuron_term_loader;
  import neuron_pkg::*;

  localparam int NT = N_INPUTS + 1;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          flush;
  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_W-1:0]             in_x;
  logic [DATA_W-1:0]             in_w;
  logic                          out_valid;
  logic                          out_ready;
  logic [N_INPUTS:0][DATA_W-1:0] out_terms;

  neuron_term_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_terms (out_terms)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] vx  [NT];
  logic [31:0] vw  [NT];
  logic [31:0] exp_t [NT];

  typedef struct {
    logic [31:0] x;
    logic [31:0] w;
    logic [31:0] y;
  } mul_vec_t;

  mul_vec_t tbl [10];

  // Reference: exact integer product, floor-divided by 2^16, then clamped or
  // reduced modulo 2^32.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] w);
    longint p;
    longint q;
    p = longint'($signed(x)) * longint'($signed(w));
    q = p / 65536;
    if (p < 0 && (p % 65536) != 0) q = q - 1;
`ifdef NEURON_TERM_SAT_EN
    if (q > 64'sd2147483647) q = 64'sd2147483647;
    else if (q < -64'sd2147483648) q = -64'sd2147483648;
`endif
    return q[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic chk_terms(input string name);
    bit bad = 0;
    checks++;
    for (int i = 0; i < NT; i++) begin
      if (out_terms[i] !== exp_t[i]) begin
        if (!bad) $display("FAIL %s: term[%0d] got %h expected %h", name, i, out_terms[i], exp_t[i]);
        bad = 1;
      end
    end
    if (bad) errors++;
  endtask

  task automatic accept_elem(input int i);
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_x     = vx[i];
    in_w     = vw[i];
    exp_t[i] = (i == N_INPUTS) ? vx[i] : ref_mul(vx[i], vw[i]);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) accept_elem(i);
  endtask

  task automatic rand_vec();
    for (int i = 0; i < NT; i++) begin
      vx[i] = $urandom;
      vw[i] = $urandom;
    end
  endtask

  // Called just after the bias-accept edge.
  task automatic tail_check(input string name);
    chk({name, "_valid_drain"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_ready_drain"}, {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk({name, "_valid_full"}, {31'd0, out_valid}, 32'd1);
    chk_terms({name, "_terms"});
  endtask

  task automatic handoff(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_ready_after_handoff"}, {31'd0, in_ready}, 32'd1);
    chk({name, "_valid_after_handoff"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    tbl[0] = '{32'h00020000, 32'h00018000, 32'h00030000};
    tbl[1] = '{32'hFFFF0000, 32'h00008000, 32'hFFFF8000};
    tbl[2] = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF};
`ifdef NEURON_TERM_SAT_EN
    tbl[3] = '{32'h7FFF0000, 32'h7FFF0000, 32'h7FFFFFFF};
    tbl[5] = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF};
    tbl[9] = '{32'hC0000000, 32'h00040000, 32'h80000000};
`else
    tbl[3] = '{32'h7FFF0000, 32'h7FFF0000, 32'h00010000};
    tbl[5] = '{32'h80000000, 32'h80000000, 32'h00000000};
    tbl[9] = '{32'hC0000000, 32'h00040000, 32'h00000000};
`endif
    tbl[4] = '{32'h00010000, 32'h00010000, 32'h00010000};
    tbl[6] = '{32'h80000000, 32'h00010000, 32'h80000000};
    tbl[7] = '{32'h00000001, 32'h00000001, 32'h00000000};
    tbl[8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_x = '0; in_w = '0;
    for (int i = 0; i < NT; i++) exp_t[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk_terms("reset_terms");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic vector: one pair, zero elsewhere, unit bias.
    for (int i = 0; i < NT; i++) begin vx[i] = '0; vw[i] = '0; end
    vx[0] = 32'h00020000; vw[0] = 32'h00018000; vx[N_INPUTS] = 32'h00010000;
    send_range(0, N_INPUTS);
    tail_check("basic");
    chk("basic_term0", out_terms[0], 32'h00030000);
    chk("basic_bias", out_terms[N_INPUTS], 32'h00010000);
    handoff("basic");

    // Table vectors at indices 0..9, random elsewhere.
    rand_vec();
    for (int i = 0; i < 10; i++) begin vx[i] = tbl[i].x; vw[i] = tbl[i].w; end
    send_range(0, N_INPUTS);
    for (int i = 0; i < 10; i++) exp_t[i] = tbl[i].y;
    tail_check("table");
    handoff("table");

    // Random vectors.
    for (int n = 0; n < 3; n++) begin
      rand_vec();
      send_range(0, N_INPUTS);
      tail_check("random");
      handoff("random");
    end

    // Back-pressure: hold FULL with in_valid asserted.
    rand_vec();
    send_range(0, N_INPUTS);
    tail_check("hold");
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_x = $urandom; in_w = $urandom;
      @(posedge clk); #1;
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk_terms("hold_terms");
    end
    in_valid = 1'b0;
    handoff("hold");
    rand_vec();
    send_range(0, N_INPUTS);
    tail_check("after_hold");
    handoff("after_hold");

    // Flush coincident with an 11th pair.
    rand_vec();
    send_range(0, 9);
    in_valid = 1'b1; flush = 1'b1; in_x = $urandom; in_w = $urandom;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    rand_vec();
    send_range(0, N_INPUTS);
    tail_check("flush");
    // Flush while FULL must not retract the vector.
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_full_valid", {31'd0, out_valid}, 32'd1);
    chk_terms("flush_full_terms");
    handoff("flush");

    // Asynchronous reset mid-vector.
    rand_vec();
    send_range(0, 19);
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < NT; i++) exp_t[i] = '0;
    chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    chk_terms("midreset_terms");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rand_vec();
    send_range(0, N_INPUTS - 1);
    repeat (3) @(posedge clk);
    #1;
    chk("postreset_not_valid", {31'd0, out_valid}, 32'd0);
    chk("postreset_in_ready", {31'd0, in_ready}, 32'd1);
    send_range(N_INPUTS, N_INPUTS);
    tail_check("postreset");
    handoff("postreset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
